// File: rtl/md_scheduler.sv
// HI/LO multiply/divide unit for the MIPS pipeline: fixed-latency mult/div
// sequencing, mthi/mtlo writes, mfhi/mflo read port and D-stage stall request.
module md_scheduler #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_md_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        E_rd_hi,
    input  logic        D_md,
    output logic [31:0] E_md_out,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] MUL_N = CW'(MUL_CYCLES);
    localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [63:0]    pend;
    logic           pend_ok;
    logic           load, commit;

    logic op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
    logic is_mul, is_div, start;

    always_comb begin
        op_mult  = 1'b0;
        op_multu = 1'b0;
        op_div   = 1'b0;
        op_divu  = 1'b0;
        op_mthi  = 1'b0;
        op_mtlo  = 1'b0;
        unique case (E_md_op)
            4'd1:    op_mult  = 1'b1;
            4'd2:    op_multu = 1'b1;
            4'd3:    op_div   = 1'b1;
            4'd4:    op_divu  = 1'b1;
            4'd5:    op_mthi  = 1'b1;
            4'd6:    op_mtlo  = 1'b1;
            default: ;
        endcase
    end

    assign is_mul = op_mult | op_multu;
    assign is_div = op_div | op_divu;
    assign start  = is_mul | is_div;

    // Signed divide runs on magnitudes so that 0x80000000 / -1 wraps cleanly.
    logic [63:0] prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

    always_comb begin
        prod = op_mult ? ({{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B})
                       : ({32'd0, E_A} * {32'd0, E_B});
        a_neg  = op_div & E_A[31];
        b_neg  = op_div & E_B[31];
        a_mag  = a_neg ? (32'd0 - E_A) : E_A;
        b_mag  = b_neg ? (32'd0 - E_B) : E_B;
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem    = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        commit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (is_mul) begin
                    state_n = MUL;
                    cnt_n   = MUL_N;
                    load    = 1'b1;
                end else if (is_div) begin
                    state_n = DIV;
                    cnt_n   = DIV_N;
                    load    = 1'b1;
                end
            end
            MUL, DIV: begin
                if (cnt == ONE) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    commit  = 1'b1;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend    <= '0;
            pend_ok <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            if (load) begin
                pend    <= is_mul ? prod : {rem, quo};
                pend_ok <= is_mul | (E_B != 32'd0);
            end
            if (commit) begin
                if (pend_ok) begin
                    HI <= pend[63:32];
                    LO <= pend[31:0];
                end
            end else if (state == IDLE) begin
                if (op_mthi) HI <= E_A;
                if (op_mtlo) LO <= E_A;
            end
        end
    end

    assign busy     = (state != IDLE);
    assign md_stall = D_md & (busy | start);
    assign E_md_out = E_rd_hi ? HI : LO;

endmodule

// File: tb/tb_md_scheduler.sv
// Randomized and directed bench for md_scheduler against a
// cycle-level arithmetic model of HI/LO and the busy window.
module tb_md_scheduler;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_md_op;
    logic [31:0] E_A, E_B;
    logic        E_rd_hi, D_md;
    logic [31:0] E_md_out, HI, LO;
    logic        busy, md_stall;

    md_scheduler #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .E_md_op(E_md_op), .E_A(E_A), .E_B(E_B),
        .E_rd_hi(E_rd_hi), .D_md(D_md), .E_md_out(E_md_out), .busy(busy),
        .md_stall(md_stall), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    // reference state: architectural HI/LO plus cycles left before commit
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          p_ok;
    int          m_left;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    function automatic void model_start(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        longint      ps;
        logic [63:0] pu;
        int          q, r;
        p_ok = 1'b1;
        case (op)
            4'd1: begin
                ps = longint'(int'(a)) * longint'(int'(b));
                pu = 64'(ps);
                p_hi = pu[63:32];
                p_lo = pu[31:0];
            end
            4'd2: begin
                pu = {32'd0, a} * {32'd0, b};
                p_hi = pu[63:32];
                p_lo = pu[31:0];
            end
            4'd3: begin
                if (b == 0) p_ok = 1'b0;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    p_lo = 32'h80000000;
                    p_hi = 32'h0;
                end else begin
                    q = int'(a) / int'(b);
                    r = int'(a) % int'(b);
                    p_lo = q;
                    p_hi = r;
                end
            end
            default: begin
                if (b == 0) p_ok = 1'b0;
                else begin
                    p_lo = a / b;
                    p_hi = a % b;
                end
            end
        endcase
        m_left = (op <= 4'd2) ? MUL_N : DIV_N;
    endfunction

    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic rdhi, input logic dmd);
        bit st;
        @(negedge clk);
        chk("busy", 32'(busy), 32'(m_left > 0));
        chk("hi", HI, m_hi);
        chk("lo", LO, m_lo);
        E_md_op = op;
        E_A = a;
        E_B = b;
        E_rd_hi = rdhi;
        D_md = dmd;
        #1;
        st = (op >= 4'd1 && op <= 4'd4);
        chk("md_stall", 32'(md_stall), 32'(dmd && (m_left > 0 || st)));
        chk("md_out", E_md_out, rdhi ? m_hi : m_lo);
        @(posedge clk);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_ok) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (st) model_start(op, a, b);
        else if (op == 4'd5) m_hi = a;
        else if (op == 4'd6) m_lo = a;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic check_hl(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        #1;
        chk({tag, "_hi"}, HI, hi);
        chk({tag, "_lo"}, LO, lo);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        E_md_op = 4'd0;
        D_md = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        m_hi = 0;
        m_lo = 0;
        m_left = 0;
        p_ok = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        E_md_op = 4'd0;
        E_A = 0;
        E_B = 0;
        E_rd_hi = 1'b0;
        D_md = 1'b0;
        m_hi = 0;
        m_lo = 0;
        m_left = 0;
        p_ok = 1'b0;
        #12;
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_hi", HI, 32'd0);
        chk("init_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        step(4'd5, 32'h12345678, 32'd0, 1'b1, 1'b0);
        step(4'd6, 32'h9ABCDEF0, 32'd0, 1'b0, 1'b0);
        step(4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        check_hl("mtx", 32'h12345678, 32'h9ABCDEF0);

        step(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
        idle(MUL_N);
        check_hl("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
        step(4'd2, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
        idle(MUL_N);
        check_hl("multu", 32'h00000002, 32'hFFFFFFFA);

        step(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        idle(DIV_N);
        check_hl("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
        step(4'd4, 32'd7, 32'd0, 1'b0, 1'b0);
        idle(DIV_N);
        check_hl("divu0", 32'hFFFFFFFF, 32'hFFFFFFFD);

        step(4'd1, 32'd100, 32'd200, 1'b0, 1'b1);
        for (int i = 0; i < MUL_N; i++)
            step((i == 1) ? 4'd1 : (i == 2) ? 4'd6 : 4'd0, 32'h55, 32'h66, 1'b0, 1'b1);
        step(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        check_hl("b2b", 32'd0, 32'd20000);

        step(4'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        idle(3);
        apply_reset();
        idle(DIV_N + 2);
        check_hl("rst_nocommit", 32'd0, 32'd0);
        step(4'd1, 32'd6, 32'd7, 1'b0, 1'b0);
        idle(MUL_N);
        check_hl("post_rst", 32'd0, 32'd42);

        step(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        idle(DIV_N);
        check_hl("div_ovf", 32'd0, 32'h80000000);
        step(4'd9, 32'h1111, 32'h2222, 1'b0, 1'b0);
        idle(1);
        check_hl("op9", 32'd0, 32'h80000000);

        for (int i = 0; i < 600; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(0, 6));
            if ($urandom_range(0, 199) == 0) apply_reset();
            step(op, rand_opnd(), rand_opnd(), 1'($urandom), 1'($urandom));
        end
        idle(DIV_N + 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
